// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared definitions for the CORDIC phase sequencer:
//   - default angle / coordinate widths matching the parallel CORDIC rotator
//   - named binary-angle constants (2^32 = 360 degrees, two's complement)
//   - sequencer FSM state type
package cordic_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned XY_W    = 16;

    localparam logic [31:0] ANG_0   = 32'h0000_0000;
    localparam logic [31:0] ANG_30  = 32'h1555_5555;
    localparam logic [31:0] ANG_45  = 32'h2000_0000;
    localparam logic [31:0] ANG_90  = 32'h4000_0000;
    localparam logic [31:0] ANG_N90 = 32'hC000_0000;
    localparam logic [31:0] ANG_120 = 32'h5555_5555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_valid_pipe.sv
// cordic_valid_pipe
// DEPTH-stage shift register carrying only the request-valid bits alongside
// the CORDIC pipeline. A synchronous flush clears every stage, including the
// bit being shifted in on that edge.
// Ports:
//   clock_i  - system clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   flush_i  - synchronous clear of all stages
//   valid_i  - valid bit entering stage 0
//   valid_o  - valid bit leaving the last stage (delayed DEPTH cycles)
//   empty_o  - no valid bit anywhere in the line
module cordic_valid_pipe #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clock_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o,
    output logic empty_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift form works for DEPTH == 1 as well, where the old bit simply drops out.
    always_comb begin
        sr_d = '0;
        if (!flush_i) begin
            sr_d = (sr_q << 1) | DEPTH'(valid_i);
        end
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o = sr_q[DEPTH-1];
    assign empty_o = ~|sr_q;

endmodule

// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer
// Upstream driver for the parallel CORDIC rotator. Generates an NCO-style
// phase sequence, issues one rotation request per cycle, tracks the CORDIC
// latency with a valid delay line and returns the results as qualified
// samples, pulsing done once the burst has fully drained.
// Ports:
//   clock, reset_n            - clock (rising edge), async active-low reset
//   start, abort              - burst start pulse / immediate termination
//   amplitude                 - x start value (gain pre-compensated by caller)
//   phase_start, phase_step   - first angle and per-sample increment
//   num_samples               - samples per burst (0 legal)
//   xstart, ystart, zangle    - rotation request to the CORDIC
//   in_valid                  - request valid this cycle
//   cordic_xout, cordic_yout  - CORDIC results
//   sample_x, sample_y        - registered results
//   sample_valid              - result valid
//   busy                      - burst in progress (RUN or DRAIN)
//   done                      - one-cycle completion pulse
module cordic_phase_sequencer #(
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned XY_W       = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned CORDIC_LAT = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [XY_W-1:0]    amplitude,
    input  logic [PHASE_W-1:0] phase_start,
    input  logic [PHASE_W-1:0] phase_step,
    input  logic [CNT_W-1:0]   num_samples,
    output logic [XY_W-1:0]    xstart,
    output logic [XY_W-1:0]    ystart,
    output logic [PHASE_W-1:0] zangle,
    output logic               in_valid,
    input  logic [XY_W-1:0]    cordic_xout,
    input  logic [XY_W-1:0]    cordic_yout,
    output logic [XY_W-1:0]    sample_x,
    output logic [XY_W-1:0]    sample_y,
    output logic               sample_valid,
    output logic               busy,
    output logic               done
);

    import cordic_pkg::*;

    state_e             state_q;
    logic [XY_W-1:0]    amp_q;
    logic [PHASE_W-1:0] step_q;
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] zangle_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               in_valid_q;
    logic [XY_W-1:0]    sample_x_q;
    logic [XY_W-1:0]    sample_y_q;
    logic               sample_valid_q;

    logic               flush;
    logic               pipe_valid;
    logic               pipe_empty;

    assign flush = abort && (state_q != IDLE);

    cordic_valid_pipe #(
        .DEPTH (CORDIC_LAT)
    ) u_valid_pipe (
        .clock_i (clock),
        .rst_ni  (reset_n),
        .flush_i (flush),
        .valid_i (in_valid_q),
        .valid_o (pipe_valid),
        .empty_o (pipe_empty)
    );

    // The first request is loaded on the start edge itself, so the
    // accumulator already holds the second angle when RUN begins and
    // remaining counts the requests still to issue after the current one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            amp_q          <= '0;
            step_q         <= '0;
            acc_q          <= '0;
            zangle_q       <= '0;
            remaining_q    <= '0;
            in_valid_q     <= 1'b0;
            sample_x_q     <= '0;
            sample_y_q     <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= pipe_valid;
            if (pipe_valid) begin
                sample_x_q <= cordic_xout;
                sample_y_q <= cordic_yout;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_samples == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q     <= RUN;
                            amp_q       <= amplitude;
                            step_q      <= phase_step;
                            zangle_q    <= phase_start;
                            acc_q       <= phase_start + phase_step;
                            remaining_q <= num_samples - CNT_W'(1);
                            in_valid_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (remaining_q == '0) begin
                        in_valid_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        zangle_q    <= acc_q;
                        acc_q       <= acc_q + step_q;
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Abort wins over everything above, including a pending done.
            if (flush) begin
                state_q        <= IDLE;
                in_valid_q     <= 1'b0;
                sample_valid_q <= 1'b0;
            end
        end
    end

    assign xstart       = amp_q;
    assign ystart       = '0;
    assign zangle       = zangle_q;
    assign in_valid     = in_valid_q;
    assign sample_x     = sample_x_q;
    assign sample_y     = sample_y_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);

endmodule

// File: doc/cordic_phase_sequencer.md
Name: cordic_phase_sequencer

Overview:
Upstream driver for the parallel CORDIC rotator. It generates a sequence of binary-angle phases (NCO-style phase accumulator), presents one rotation request per cycle on xstart/ystart/zangle, and aligns a valid flag with the CORDIC's fixed pipeline latency. It returns the CORDIC results as qualified samples and signals burst completion. Angle format: 2^32 = 360°, signed two's complement, so 0x4000_0000 = 90° and 0xC000_0000 = -90°.

Parameters:
PHASE_W, 32, angle/accumulator width (matches CORDIC zangle)
XY_W, 16, coordinate width (matches CORDIC xstart/ystart/xout/yout)
CNT_W, 16, sample-count width
CORDIC_LAT, 16, cycles from CORDIC input capture to valid xout/yout (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a burst when idle
abort  in  1  terminates the burst immediately
amplitude  in  XY_W  x start value; caller pre-compensates CORDIC gain
phase_start  in  PHASE_W  first angle of the burst
phase_step  in  PHASE_W  per-sample angle increment (signed, modulo 2^32)
num_samples  in  CNT_W  samples per burst; 0 is legal
xstart  out  XY_W  to CORDIC
ystart  out  XY_W  to CORDIC, always 0
zangle  out  PHASE_W  to CORDIC
in_valid  out  1  xstart/zangle carry a real request this cycle
cordic_xout  in  XY_W  from CORDIC
cordic_yout  in  XY_W  from CORDIC
sample_x  out  XY_W  registered cordic_xout
sample_y  out  XY_W  registered cordic_yout
sample_valid  out  1  sample_x/sample_y valid
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; all outputs 0; accumulator, counter, and delay line cleared.
- FSM IDLE -> RUN on start (num_samples>0): latch amplitude, phase_step, and num_samples; acc=phase_start.
- IDLE with start and num_samples==0: go straight to DONE; done pulses in the next cycle; in_valid never asserts.
- RUN: each cycle, in_valid=1, zangle=acc, xstart=amplitude, ystart=0; acc<=acc+step, truncated to PHASE_W (wrap is silent and intended); remaining<=remaining-1. The first in_valid appears in the cycle after start is sampled. When the last request issues -> DRAIN.
- DRAIN: in_valid=0 and zangle holds its last value. Wait until the delay line is empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in DONE.
- Delay line: in_valid is delayed by CORDIC_LAT cycles, then registered once more. sample_valid for request k is high exactly CORDIC_LAT+1 cycles after its in_valid. sample_x and sample_y update only when the delayed valid is high; otherwise they hold.
- start while busy: ignored. Latched parameters are unaffected by input changes mid-burst.
- abort (any state except IDLE): next cycle state=IDLE; in_valid, sample_valid, and the delay line are cleared; done is NOT pulsed. abort has priority over start in the same cycle.
- Throughput: one sample per cycle, no back-pressure. The CORDIC accepts every cycle.

Decomposition:
- cordic_pkg: PHASE_W, XY_W, named angle constants (ANG_0, ANG_30=0x1555_5555, ANG_45=0x2000_0000, ANG_90=0x4000_0000, ANG_N90=0xC000_0000, ANG_120=0x5555_5555), and the FSM enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module cordic_valid_pipe: a parameterised CORDIC_LAT-deep shift register with synchronous flush, holding the valid bits only.

Test Plan:
- Basic burst: amplitude=1200, phase_start=0, step=0x1555_5555, N=4 -> zangle 0x0000_0000, 0x1555_5555, 0x2AAA_AAAA, 0x3FFF_FFFF on 4 consecutive in_valid cycles. sample_valid high 4 cycles, starting CORDIC_LAT+1 after the first in_valid. done pulses in the cycle after the last sample_valid.
- Wrap: phase_start=0xF000_0000, step=0x2000_0000, N=3 -> zangle 0xF000_0000, 0x1000_0000, 0x3000_0000. Negative step 0xE000_0000 from 0 -> 0, 0xE000_0000, 0xC000_0000.
- N=0: start -> no in_valid, no sample_valid; done for one cycle; busy never set.
- Abort: N=10, abort after the 3rd in_valid -> in_valid=0 and sample_valid=0 from the next cycle, no done, busy=0. A new start then runs a full, clean burst.
- Start while busy: a second start with different phase_start mid-burst -> sequence unchanged, exactly N samples.
- Async reset mid-DRAIN: reset_n low between clock edges -> all outputs 0 immediately. After release, state is IDLE and no stale sample_valid appears.
